// File: rtl/uart_pkg.sv
// Shared UART register map, CON bit positions and FSM state encoding.
// Pure declarations; no latency, no backpressure.
package uart_pkg;

    localparam logic [31:0] TXD_ADDR_DEF = 32'h4000_0018;
    localparam logic [31:0] RXD_ADDR_DEF = 32'h4000_001C;
    localparam logic [31:0] CON_ADDR_DEF = 32'h4000_0020;

    localparam int CON_RX_IE    = 0;
    localparam int CON_TX_IE    = 1;
    localparam int CON_RX_VALID = 2;
    localparam int CON_TX_DONE  = 3;
    localparam int CON_TX_BUSY  = 4;
    localparam int CON_FERR     = 5;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// 8N1 receiver: 2-flop synchroniser, mid-bit sampling, one-cycle byte/ferr strobes.
// Strobes fire one cycle after the stop-bit sample; no backpressure (strobes are not held).
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int DIV = 16
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] rx_byte,
    output logic       byte_stb,
    output logic       ferr_stb
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

    logic        sync1_q, sync2_q;
    uart_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        byte_stb_q, byte_stb_d;
    logic        ferr_stb_q, ferr_stb_d;

    // Synchroniser resets to the idle-high level so reset release is not seen as a start bit.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            byte_stb_q <= 1'b0;
            ferr_stb_q <= 1'b0;
        end else begin
            sync1_q    <= rx_in;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            byte_stb_q <= byte_stb_d;
            ferr_stb_q <= ferr_stb_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_stb_d = 1'b0;
        ferr_stb_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!sync2_q) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (sync2_q) byte_stb_d = 1'b1;
                    else         ferr_stb_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_byte  = shift_q;
    assign byte_stb = byte_stb_q;
    assign ferr_stb = ferr_stb_q;

endmodule

// File: rtl/uart_bus_responder.sv
// Memory-mapped UART target: TXD/RXD/CON registers, TX serialiser, masked level interrupt.
// Reads are combinational, writes take one edge; TXD writes while busy are dropped.
module uart_bus_responder
    import uart_pkg::*;
#(
    parameter int          CLK_HZ   = 50000000,
    parameter int          BAUD     = 9600,
    parameter logic [31:0] TXD_ADDR = TXD_ADDR_DEF,
    parameter logic [31:0] RXD_ADDR = RXD_ADDR_DEF,
    parameter logic [31:0] CON_ADDR = CON_ADDR_DEF
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        PC31,
    input  logic        UART_RX,
    output logic        UART_TX,
    output logic        irqout
);

    localparam int DIV = baud_div(CLK_HZ, BAUD);
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

    logic        sel_txd, sel_rxd, sel_con;
    logic        tx_busy, tx_done_set;
    logic [5:0]  con_val;
    logic [7:0]  rx_shift_byte;
    logic        rx_byte_stb, rx_ferr_stb;
    logic        unused_wdata;

    uart_state_e tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  txd_q, txd_d;
    logic        tx_line_q, tx_line_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        rx_valid_q, rx_valid_d;
    logic        tx_done_q, tx_done_d;
    logic        ferr_q, ferr_d;
    logic        rx_ie_q, rx_ie_d;
    logic        tx_ie_q, tx_ie_d;
    logic        irq_q, irq_d;

    uart_rx_sampler #(.DIV(DIV)) u_rx (
        .sysclk   (sysclk),
        .reset    (reset),
        .rx_in    (UART_RX),
        .rx_byte  (rx_shift_byte),
        .byte_stb (rx_byte_stb),
        .ferr_stb (rx_ferr_stb)
    );

    assign unused_wdata = ^wdata[31:8];
    assign sel_txd = (addr == TXD_ADDR);
    assign sel_rxd = (addr == RXD_ADDR);
    assign sel_con = (addr == CON_ADDR);
    assign tx_busy = (tx_state_q != IDLE);

    always_comb begin
        con_val               = '0;
        con_val[CON_RX_IE]    = rx_ie_q;
        con_val[CON_TX_IE]    = tx_ie_q;
        con_val[CON_RX_VALID] = rx_valid_q;
        con_val[CON_TX_DONE]  = tx_done_q;
        con_val[CON_TX_BUSY]  = tx_busy;
        con_val[CON_FERR]     = ferr_q;
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (sel_txd)      rdata = {24'b0, txd_q};
            else if (sel_rxd) rdata = {24'b0, rx_byte_q};
            else if (sel_con) rdata = {26'b0, con_val};
        end
    end

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q + CW'(1);
        tx_bit_d    = tx_bit_q;
        txd_d       = txd_q;
        tx_done_set = 1'b0;
        case (tx_state_q)
            IDLE: begin
                tx_cnt_d = '0;
                if (wr && sel_txd) begin
                    txd_d      = wdata[7:0];
                    tx_state_d = START;
                end
            end
            START: begin
                if (tx_cnt_q == FULL_M1) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = DATA;
                end
            end
            DATA: begin
                if (tx_cnt_q == FULL_M1) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) tx_state_d = STOP;
                    else                  tx_bit_d   = tx_bit_q + 3'd1;
                end
            end
            STOP: begin
                if (tx_cnt_q == FULL_M1) begin
                    tx_cnt_d    = '0;
                    tx_state_d  = IDLE;
                    tx_done_set = 1'b1;
                end
            end
            default: tx_state_d = IDLE;
        endcase

        // Line level follows the state being entered so the pin itself is a flop.
        case (tx_state_d)
            START:   tx_line_d = 1'b0;
            DATA:    tx_line_d = txd_d[tx_bit_d];
            default: tx_line_d = 1'b1;
        endcase
    end

    always_comb begin
        rx_byte_d  = rx_byte_q;
        rx_valid_d = rx_valid_q;
        tx_done_d  = tx_done_q;
        ferr_d     = ferr_q;
        rx_ie_d    = rx_ie_q;
        tx_ie_d    = tx_ie_q;
        if (wr && sel_con) begin
            rx_ie_d = wdata[CON_RX_IE];
            tx_ie_d = wdata[CON_TX_IE];
        end
        if (rd && sel_rxd) rx_valid_d = 1'b0;
        if (rd && sel_con) begin
            tx_done_d = 1'b0;
            ferr_d    = 1'b0;
        end
        // Set events are applied after read-clears so they win on collision.
        if (tx_done_set) tx_done_d = 1'b1;
        if (rx_ferr_stb) ferr_d    = 1'b1;
        if (rx_byte_stb) begin
            rx_byte_d  = rx_shift_byte;
            rx_valid_d = 1'b1;
        end
        irq_d = ~PC31 & ((rx_ie_d & rx_valid_d) | (tx_ie_d & tx_done_d));
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            txd_q      <= '0;
            tx_line_q  <= 1'b1;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_done_q  <= 1'b0;
            ferr_q     <= 1'b0;
            rx_ie_q    <= 1'b0;
            tx_ie_q    <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            txd_q      <= txd_d;
            tx_line_q  <= tx_line_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            tx_done_q  <= tx_done_d;
            ferr_q     <= ferr_d;
            rx_ie_q    <= rx_ie_d;
            tx_ie_q    <= tx_ie_d;
            irq_q      <= irq_d;
        end
    end

    assign UART_TX = tx_line_q;
    assign irqout  = irq_q;

endmodule

// File: tb/tb_uart_bus_responder.sv
// Directed bench for uart_bus_responder at DIV=16 (CLK_HZ=16, BAUD=1).
module tb_uart_bus_responder;

    localparam logic [31:0] TXD = 32'h4000_0018;
    localparam logic [31:0] RXD = 32'h4000_001C;
    localparam logic [31:0] CON = 32'h4000_0020;

    logic        sysclk = 1'b0;
    logic        reset  = 1'b0;
    logic        rd     = 1'b0;
    logic        wr     = 1'b0;
    logic [31:0] addr   = '0;
    logic [31:0] wdata  = '0;
    logic [31:0] rdata;
    logic        PC31    = 1'b0;
    logic        UART_RX = 1'b1;
    logic        UART_TX;
    logic        irqout;

    int total = 0;
    int bad   = 0;

    uart_bus_responder #(.CLK_HZ(16), .BAUD(1)) dut (
        .sysclk  (sysclk),
        .reset   (reset),
        .rd      (rd),
        .wr      (wr),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .PC31    (PC31),
        .UART_RX (UART_RX),
        .UART_TX (UART_TX),
        .irqout  (irqout)
    );

    always #5 sysclk = ~sysclk;

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        rd   = 1'b1;
        addr = a;
        #1;
        d    = rdata;
        rd   = 1'b0;
        addr = '0;
    endtask

    task automatic rd_clk(input logic [31:0] a);
        rd   = 1'b1;
        addr = a;
        step();
        rd   = 1'b0;
        addr = '0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        wr    = 1'b1;
        addr  = a;
        wdata = d;
        step();
        wr    = 1'b0;
        addr  = '0;
        wdata = '0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            UART_RX = frame[i];
            repeat (16) step();
        end
        UART_RX = 1'b1;
        repeat (24) step();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) step();
        total++;
        if (UART_TX !== 1'b1) begin bad++; $display("FAIL reset_tx_held got %b want 1", UART_TX); end
        reset = 1'b1;
        repeat (2) step();
        peek(CON, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL reset_con got %h want 0", d); end
        peek(RXD, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL reset_rxd got %h want 0", d); end
        peek(TXD, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL reset_txd got %h want 0", d); end
        total++;
        if (UART_TX !== 1'b1) begin bad++; $display("FAIL reset_tx got %b want 1", UART_TX); end
        total++;
        if (irqout !== 1'b0) begin bad++; $display("FAIL reset_irq got %b want 0", irqout); end
    endtask

    // Transmit one byte and check every line sample; extras adds a dropped write,
    // a mid-frame register check and a CON read colliding with frame completion.
    task automatic tx_frame(input logic [7:0] b, input bit extras);
        logic [31:0] d;
        logic        exp_line;
        bus_write(TXD, {24'h0, b});
        for (int s = 1; s <= 160; s++) begin
            if (s <= 16)       exp_line = 1'b0;
            else if (s <= 144) exp_line = b[(s - 17) / 16];
            else               exp_line = 1'b1;
            total++;
            if (UART_TX !== exp_line) begin
                bad++;
                $display("FAIL tx_line sample %0d got %b want %b", s, UART_TX, exp_line);
            end
            if (extras && s == 50) begin
                wr = 1'b1; addr = TXD; wdata = 32'h0000_003C;
            end
            if (extras && s == 60) begin
                peek(TXD, d);
                total++;
                if (d !== {24'h0, b}) begin bad++; $display("FAIL txd_after_drop got %h want %h", d, b); end
                peek(CON, d);
                total++;
                if (d[4] !== 1'b1) begin bad++; $display("FAIL tx_busy_mid got %b want 1", d[4]); end
            end
            if (extras && s == 160) begin
                rd = 1'b1; addr = CON;
            end
            step();
            wr = 1'b0; wdata = '0;
            if (!rd) addr = '0;
        end
        if (extras) begin
            total++;
            if (rdata !== 32'h08) begin bad++; $display("FAIL con_done_setwins got %h want 08", rdata); end
            step();
            total++;
            if (rdata !== 32'h0) begin bad++; $display("FAIL con_done_cleared got %h want 0", rdata); end
            rd = 1'b0; addr = '0;
        end else begin
            peek(CON, d);
            total++;
            if (d !== 32'h08) begin bad++; $display("FAIL con_done got %h want 08", d); end
            rd_clk(CON);
            peek(CON, d);
            total++;
            if (d !== 32'h0) begin bad++; $display("FAIL con_done_cleared got %h want 0", d); end
        end
        total++;
        if (irqout !== 1'b0) begin bad++; $display("FAIL tx_irq_masked_by_ie got %b want 0", irqout); end
    endtask

    task automatic test_tx();
        tx_frame(8'hA5, 1'b1);
    endtask

    task automatic test_rx();
        logic [31:0] d;
        bus_write(CON, 32'hFFFF_FFFD);
        peek(CON, d);
        total++;
        if (d !== 32'h01) begin bad++; $display("FAIL con_write_mask got %h want 01", d); end

        send_rx(8'h5A, 1'b1);
        peek(CON, d);
        total++;
        if (d !== 32'h05) begin bad++; $display("FAIL rx_con got %h want 05", d); end
        total++;
        if (irqout !== 1'b1) begin bad++; $display("FAIL rx_irq got %b want 1", irqout); end
        peek(RXD, d);
        total++;
        if (d !== 32'h5A) begin bad++; $display("FAIL rxd_5a got %h want 5a", d); end
        rd_clk(RXD);
        total++;
        if (irqout !== 1'b0) begin bad++; $display("FAIL irq_after_rxd_read got %b want 0", irqout); end
        peek(CON, d);
        total++;
        if (d !== 32'h01) begin bad++; $display("FAIL rx_valid_cleared got %h want 01", d); end

        PC31 = 1'b1;
        send_rx(8'h81, 1'b1);
        peek(CON, d);
        total++;
        if (d !== 32'h05) begin bad++; $display("FAIL rx_con_kernel got %h want 05", d); end
        total++;
        if (irqout !== 1'b0) begin bad++; $display("FAIL irq_kernel_mask got %b want 0", irqout); end
        peek(RXD, d);
        total++;
        if (d !== 32'h81) begin bad++; $display("FAIL rxd_81 got %h want 81", d); end
        PC31 = 1'b0;
        step();
        total++;
        if (irqout !== 1'b1) begin bad++; $display("FAIL irq_unmask got %b want 1", irqout); end
        rd_clk(RXD);
    endtask

    task automatic test_glitch_ferr();
        logic [31:0] d;
        UART_RX = 1'b0;
        repeat (4) step();
        UART_RX = 1'b1;
        repeat (30) step();
        peek(CON, d);
        total++;
        if (d !== 32'h01) begin bad++; $display("FAIL glitch_con got %h want 01", d); end
        total++;
        if (irqout !== 1'b0) begin bad++; $display("FAIL glitch_irq got %b want 0", irqout); end

        send_rx(8'h11, 1'b1);
        send_rx(8'hC3, 1'b0);
        peek(CON, d);
        total++;
        if (d !== 32'h25) begin bad++; $display("FAIL ferr_con got %h want 25", d); end
        peek(RXD, d);
        total++;
        if (d !== 32'h11) begin bad++; $display("FAIL ferr_rxd_kept got %h want 11", d); end
        rd_clk(CON);
        peek(CON, d);
        total++;
        if (d !== 32'h05) begin bad++; $display("FAIL ferr_cleared got %h want 05", d); end
    endtask

    task automatic test_reset_mid_tx();
        logic [31:0] d;
        bus_write(CON, 32'h3);
        bus_write(TXD, 32'hF0);
        repeat (69) step();
        total++;
        if (UART_TX !== 1'b0) begin bad++; $display("FAIL mid_bit3 got %b want 0", UART_TX); end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (UART_TX !== 1'b1) begin bad++; $display("FAIL reset_mid_tx_line got %b want 1", UART_TX); end
        total++;
        if (irqout !== 1'b0) begin bad++; $display("FAIL reset_mid_irq got %b want 0", irqout); end
        peek(CON, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL reset_mid_con got %h want 0", d); end
        peek(RXD, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL reset_mid_rxd got %h want 0", d); end
        step();
        reset = 1'b1;
        repeat (2) step();
        tx_frame(8'h96, 1'b0);
    endtask

    initial begin
        test_reset();
        test_tx();
        test_rx();
        test_glitch_ferr();
        test_reset_mid_tx();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
